multi_ps2_ioadapter: RTL and testbench

Parametrised PS/2 pad adapter serving NUM_CH open-drain PS/2 ports (clock + data each) between the IOBUF I/O/T triplets and the PS/2 controller cores. Synchronises and glitch-filters every incoming line, generates a one-cycle falling-edge strobe on each filtered PS/2 clock, and drives lines low open-drain on request. A per-channel watchdog releases a clock-inhibit that is held too long and flags it.

---
 rtl/multi_ps2_ioadapter.sv | 92 +++++++++
 tb/tb_multi_ps2_ioadapter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ps2_ioadapter.sv
// rtl/multi_ps2_ioadapter.sv - open-drain PS/2 pad adapter with glitch filters and clock-inhibit watchdog
module multi_ps2_ioadapter #(
  parameter int NUM_CH      = 2,
  parameter int FILTER_LEN  = 4,
  parameter int MAX_INHIBIT = 0
) (
  input  logic              OPB_Clk,
  input  logic              OPB_Rst,
  input  logic [NUM_CH-1:0] ps2_clk_I,
  output logic [NUM_CH-1:0] ps2_clk_O,
  output logic [NUM_CH-1:0] ps2_clk_T,
  input  logic [NUM_CH-1:0] ps2_data_I,
  output logic [NUM_CH-1:0] ps2_data_O,
  output logic [NUM_CH-1:0] ps2_data_T,
  input  logic [NUM_CH-1:0] ps2_clk_tx,
  input  logic [NUM_CH-1:0] ps2_d_tx,
  output logic [NUM_CH-1:0] ps2_clk_rx,
  output logic [NUM_CH-1:0] ps2_d_rx,
  output logic [NUM_CH-1:0] ps2_clk_fall,
  output logic [NUM_CH-1:0] inhibit_timeout,
  input  logic [NUM_CH-1:0] timeout_clr
);

  localparam int NL = 2 * NUM_CH;
  localparam logic [7:0]  FL_LAST = 8'(FILTER_LEN - 1);
  localparam bit          WD_EN   = (MAX_INHIBIT > 0);
  localparam logic [23:0] WD_LAST = 24'(WD_EN ? MAX_INHIBIT - 1 : 0);

  // Lines [NUM_CH-1:0] are the clocks, [NL-1:NUM_CH] the data lines.
  logic [NL-1:0] pad, s1, s2, filt;
  logic [7:0]    cnt [NL];
  logic [NUM_CH-1:0] rel;
  logic [23:0]       wcnt [NUM_CH];

  assign pad        = {ps2_data_I, ps2_clk_I};
  assign ps2_clk_O  = '0;
  assign ps2_data_O = '0;
  assign ps2_clk_rx = filt[NUM_CH-1:0];
  assign ps2_d_rx   = filt[NL-1:NUM_CH];

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      s1           <= '1;
      s2           <= '1;
      filt         <= '1;
      ps2_clk_fall <= '0;
      for (int j = 0; j < NL; j++) cnt[j] <= '0;
    end else begin
      s1 <= pad;
      s2 <= s1;
      for (int j = 0; j < NL; j++) begin
        if (s2[j] == filt[j]) begin
          cnt[j] <= '0;
        end else if (cnt[j] == FL_LAST) begin
          filt[j] <= s2[j];
          cnt[j]  <= '0;
        end else begin
          cnt[j] <= cnt[j] + 8'd1;
        end
      end
      // Strobe coincides with the filtered clock accepting a 1->0 change.
      for (int i = 0; i < NUM_CH; i++)
        ps2_clk_fall[i] <= filt[i] & ~s2[i] & (cnt[i] == FL_LAST);
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      ps2_clk_T       <= '1;
      ps2_data_T      <= '1;
      rel             <= '0;
      inhibit_timeout <= '0;
      for (int i = 0; i < NUM_CH; i++) wcnt[i] <= '0;
    end else begin
      ps2_data_T <= ~ps2_d_tx;
      for (int i = 0; i < NUM_CH; i++) begin
        ps2_clk_T[i] <= ~(ps2_clk_tx[i] & ~rel[i]);
        if (!ps2_clk_tx[i]) begin
          wcnt[i] <= '0;
          rel[i]  <= 1'b0;
        end else if (WD_EN && !rel[i]) begin
          if (wcnt[i] == WD_LAST) rel[i] <= 1'b1;
          else                    wcnt[i] <= wcnt[i] + 24'd1;
        end
        // Flag rises on the edge the watchdog actually releases the pad.
        if (rel[i] & ps2_clk_tx[i] & ~ps2_clk_T[i]) inhibit_timeout[i] <= 1'b1;
        else if (timeout_clr[i])                     inhibit_timeout[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_ps2_ioadapter.sv
// tb/tb_multi_ps2_ioadapter.sv - randomized and directed checks of multi_ps2_ioadapter against a behavioural model
module tb_multi_ps2_ioadapter;
  localparam int NC = 2;
  localparam int FL = 4;
  localparam int MI = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0] clk_I = '1, data_I = '1, clk_tx = '0, d_tx = '0, clr = '0;
  logic [NC-1:0] clk_O, clk_T, data_O, data_T, clk_rx, d_rx, clk_fall, tmo;

  int vectors = 0;
  int miscompares = 0;

  multi_ps2_ioadapter #(.NUM_CH(NC), .FILTER_LEN(FL), .MAX_INHIBIT(MI)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst),
    .ps2_clk_I(clk_I), .ps2_clk_O(clk_O), .ps2_clk_T(clk_T),
    .ps2_data_I(data_I), .ps2_data_O(data_O), .ps2_data_T(data_T),
    .ps2_clk_tx(clk_tx), .ps2_d_tx(d_tx),
    .ps2_clk_rx(clk_rx), .ps2_d_rx(d_rx), .ps2_clk_fall(clk_fall),
    .inhibit_timeout(tmo), .timeout_clr(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: a line's filtered level takes a new value once the
  // last FL synchronised samples (pad delayed two edges) all differ from it.
  bit m_p1 [2][NC];
  bit m_p2 [2][NC];
  bit m_win [2][NC][FL];
  bit m_filt [2][NC];
  bit m_fall [NC];
  bit m_cT [NC];
  bit m_dT [NC];
  bit m_tmo [NC];
  int m_ht [NC];

  always @(posedge clk) begin
    logic [NC-1:0] e_crx, e_drx, e_fall, e_cT, e_dT, e_tmo;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        for (int l = 0; l < 2; l++) begin
          m_p1[l][i] = 1; m_p2[l][i] = 1; m_filt[l][i] = 1;
          for (int w = 0; w < FL; w++) m_win[l][i][w] = 1;
        end
        m_fall[i] = 0; m_cT[i] = 1; m_dT[i] = 1; m_tmo[i] = 0; m_ht[i] = 0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        m_fall[i] = 0;
        for (int l = 0; l < 2; l++) begin
          bit s;
          bit alld;
          s = m_p2[l][i];
          for (int w = 0; w < FL - 1; w++) m_win[l][i][w] = m_win[l][i][w+1];
          m_win[l][i][FL-1] = s;
          alld = 1;
          for (int w = 0; w < FL; w++) if (m_win[l][i][w] == m_filt[l][i]) alld = 0;
          if (alld) begin
            if (l == 0 && m_filt[l][i] == 1) m_fall[i] = 1;
            m_filt[l][i] = s;
          end
          m_p2[l][i] = m_p1[l][i];
          m_p1[l][i] = (l == 0) ? clk_I[i] : data_I[i];
        end
        m_dT[i] = !d_tx[i];
        if (clk_tx[i]) begin
          if (m_ht[i] < MI + 2) m_ht[i]++;
        end else begin
          m_ht[i] = 0;
        end
        m_cT[i] = !(clk_tx[i] && m_ht[i] <= MI);
        if (clk_tx[i] && m_ht[i] == MI + 1) m_tmo[i] = 1;
        else if (clr[i])                    m_tmo[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < NC; i++) begin
      e_crx[i] = m_filt[0][i]; e_drx[i] = m_filt[1][i]; e_fall[i] = m_fall[i];
      e_cT[i] = m_cT[i]; e_dT[i] = m_dT[i]; e_tmo[i] = m_tmo[i];
    end
    chk("clk_rx", clk_rx, e_crx);
    chk("d_rx", d_rx, e_drx);
    chk("clk_fall", clk_fall, e_fall);
    chk("clk_T", clk_T, e_cT);
    chk("data_T", data_T, e_dT);
    chk("inhibit_timeout", tmo, e_tmo);
    chk("pad_O", {clk_O, data_O}, '0);
  end

  bit collect = 0;
  bit got[$];
  always @(posedge clk) begin
    #1;
    if (collect && clk_fall[1]) got.push_back(d_rx[1]);
  end

  bit frame [11] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};

  initial begin
    int low_cnt, first, nfall;
    bit rxh [21];
    bit fh [21];
    bit ch1_moved;

    tick(3);
    rst = 1'b0;

    // Idle pads after reset.
    tick(100);
    #1;
    chk("idle_clk_T", clk_T, 2'b11);
    chk("idle_data_T", data_T, 2'b11);
    chk("idle_rx", {clk_rx, d_rx}, 4'hF);
    chk("idle_fall_tmo", {clk_fall, tmo}, 4'h0);

    // 3-cycle glitch must not pass the filter.
    @(negedge clk); clk_I[0] = 0;
    tick(3); clk_I[0] = 1;
    first = 0; nfall = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (!clk_rx[0]) first++;
      if (clk_fall[0]) nfall++;
    end
    chk("glitch_rx_low_cycles", first, 0);
    chk("glitch_strobes", nfall, 0);

    // 10-cycle low: rx falls on the 6th edge after first sampling.
    @(negedge clk); clk_I[0] = 0;
    fork
      begin tick(10); clk_I[0] = 1; end
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        rxh[n] = clk_rx[0]; fh[n] = clk_fall[0];
        if (clk_rx[1] !== 1'b1) ch1_moved = 1;
      end
    join
    first = 0; nfall = 0;
    for (int n = 1; n <= 20; n++) begin
      if (!rxh[n] && first == 0) first = n;
      if (fh[n]) nfall++;
    end
    chk("fall_latency", first, FL + 2);
    chk("fall_strobe_count", nfall, 1);
    chk("fall_strobe_at_edge", fh[FL+2], 1);
    chk("ch1_unaffected", ch1_moved, 0);

    // 5-cycle data pull.
    @(negedge clk); d_tx[0] = 1;
    low_cnt = 0; first = 0;
    fork
      begin tick(5); d_tx[0] = 0; end
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk); #1;
        if (!data_T[0]) begin low_cnt++; if (first == 0) first = n; end
      end
    join
    chk("data_T_low_cycles", low_cnt, 5);
    chk("data_T_first_low", first, 1);

    // Clock inhibit watchdog.
    @(negedge clk); clk_tx[1] = 1;
    low_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (!clk_T[1]) low_cnt++;
    end
    chk("inhibit_low_cycles", low_cnt, MI);
    chk("timeout_set", tmo[1], 1);
    @(negedge clk); clk_tx[1] = 0;
    tick(5);
    chk("timeout_sticky", tmo[1], 1);
    clr[1] = 1; tick(1); clr[1] = 0;
    chk("timeout_cleared", tmo[1], 0);
    clk_tx[1] = 1;
    tick(MI);
    clr[1] = 1; tick(1); clr[1] = 0;
    chk("timeout_set_beats_clr", tmo[1], 1);
    clk_tx[1] = 0;
    clr[1] = 1; tick(1); clr[1] = 0;
    chk("timeout_clr_again", tmo[1], 0);

    // 11-bit frame on channel 1 with data glitches.
    collect = 1;
    for (int b = 0; b < 11; b++) begin
      data_I[1] = frame[b];
      tick(5); data_I[1] = ~frame[b]; tick(1); data_I[1] = frame[b];
      tick(14); clk_I[1] = 0;
      tick(8); data_I[1] = ~frame[b]; tick(1); data_I[1] = frame[b];
      tick(11); clk_I[1] = 1;
    end
    tick(20);
    collect = 0;
    chk("frame_strobes", got.size(), 11);
    for (int b = 0; b < 11; b++)
      chk("frame_bit", (b < got.size()) ? 32'(got[b]) : 32'hFFFF_FFFF, 32'(frame[b]));

    // Asynchronous reset while pulling and mid-filter.
    clk_tx = '1; d_tx = '1;
    clk_I = '0; data_I = '0;
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_clk_T", clk_T, 2'b11);
    chk("async_rst_data_T", data_T, 2'b11);
    chk("async_rst_rx", {clk_rx, d_rx}, 4'hF);
    clk_I = '1; data_I = '1; clk_tx = '0; d_tx = '0;
    tick(2);
    rst = 1'b0;
    nfall = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (clk_fall != '0) nfall++;
    end
    chk("no_strobe_after_rst", nfall, 0);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(5) == 0)   clk_I[i]  = ~clk_I[i];
        if ($urandom_range(5) == 0)   data_I[i] = ~data_I[i];
        if ($urandom_range(7) == 0)   d_tx[i]   = ~d_tx[i];
        if ($urandom_range(149) == 0) clk_tx[i] = ~clk_tx[i];
        clr[i] = ($urandom_range(19) == 0);
      end
    end
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
